program_sequencer: RTL and testbench
====================================

# program_sequencer

Control FSM that sequences the fetch stage (IF + InstrROM) through one of several stored programs. It accepts a host run request with a program index, drives the IF stage's `Start`/`Start_Addr` to load that program's entry PC, and gates PC advance while the program runs. It detects completion (decoder halt) or a watchdog timeout, reports the executed cycle count, and completes a level handshake back to the host or testbench. It sits between the top-level test harness and the IF module.

## Interface
- `NUM_PROGS`, 3: number of selectable programs (1–4).
- `PROG0_ADDR`, 8'd0: entry PC of program 0.
- `PROG1_ADDR`, 8'd64: entry PC of program 1.
- `PROG2_ADDR`, 8'd128: entry PC of program 2.
- `PROG3_ADDR`, 8'd192: entry PC of program 3.
- `TIMEOUT`, 16'd4096: RUN-cycle limit before forced stop (≥2).

Ports:
- `CLK` in 1: single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Req` in 1: host run request; level; held until `Done` is seen.
- `ProgSel` in 2: program index; sampled only when a request is accepted.
- `Halt` in 1: decoder has executed a halt instruction (valid during RUN).
- `IF_Start` out 1: drives IF `Start`.
- `IF_Start_Addr` out 8: drives IF `Start_Addr`.
- `Run` out 1: PC advance enable to IF; 0 freezes the PC.
- `Busy` out 1: FSM is in LOAD or RUN.
- `Done` out 1: completion level, held during DONE.
- `Timeout` out 1: last run ended by watchdog; valid while `Done`=1.
- `Err` out 1: one-cycle pulse on an invalid `ProgSel`.
- `CycleCount` out 16: RUN cycles of the current or last program.

## Operation
- States: IDLE, LOAD, RUN, DONE. Outputs are Moore, decoded from registered state and registered data.
- Reset (any state, any cycle): state→IDLE. All outputs 0, including `CycleCount`, `IF_Start_Addr` and `Timeout`.
- IDLE, `Req`=1 and `ProgSel`<NUM_PROGS:
  - Latch the entry address for `ProgSel` into `IF_Start_Addr`.
  - Clear `CycleCount` and `Timeout`; go to LOAD.
- IDLE, `Req`=1 and `ProgSel`≥NUM_PROGS:
  - `Err`=1 for the next cycle only; stay in IDLE.
  - Re-evaluates every cycle, so `Err` pulses once per cycle while the bad request is held.
- LOAD (exactly 1 cycle): `IF_Start`=1, `Busy`=1, `Run`=0. Next state is RUN.
- RUN: `Run`=1, `Busy`=1. `CycleCount` increments by 1 every cycle in RUN. Exits:
  - `Halt`=1 → DONE, `Timeout` stays 0.
  - Else, if `CycleCount`==TIMEOUT−1 (this is the TIMEOUT-th RUN cycle) → DONE, `Timeout`=1.
  - Halt and timeout in the same cycle: halt wins, `Timeout`=0.
- DONE: `Done`=1, `Run`=0, `Busy`=0. `CycleCount` and `Timeout` are held.
  - Returns to IDLE when `Req`=0.
  - A new run needs `Req` low for at least 1 cycle.
- `Req` and `ProgSel` are ignored in LOAD and RUN; dropping `Req` mid-run does not abort the run.
- `Halt` is ignored outside RUN.
- `IF_Start_Addr` holds its value after LOAD until the next accepted request or reset.

## Timing
- Request accepted at edge t (IDLE, `Req`=1): `IF_Start`=1 during cycle t..t+1.
- IF loads its PC at edge t+1. `Run`=1 from edge t+1 onward, so the first instruction executes in cycle t+1..t+2.
- `Halt` sampled high at edge h: `Run`=0 and `Done`=1 from edge h. `CycleCount` counts the halt cycle.
- Latency from request to first fetch: 1 cycle. From halt to `Done`: 0 cycles after the sampling edge.
- `CycleCount` never exceeds TIMEOUT.
- Reset asserted at edge r: all outputs 0 from edge r. The FSM leaves IDLE no earlier than the first edge after `Reset` is deasserted.

## Test plan
- Reset, then `Req`=1, `ProgSel`=1: one cycle of `IF_Start`=1 with `IF_Start_Addr`=64, then `Run`=1. Assert `Halt` on the 5th RUN cycle → `Done`=1, `CycleCount`=5, `Timeout`=0. Drop `Req` → IDLE next cycle.
- `ProgSel`=3 with NUM_PROGS=3: `Err` pulses, `IF_Start` stays 0, `Busy` stays 0, `IF_Start_Addr` unchanged.
- TIMEOUT=20, no `Halt`: `Done`=1 and `Timeout`=1 after exactly 20 RUN cycles, `CycleCount`=20.
- TIMEOUT=20, `Halt`=1 on RUN cycle 20: `Done`=1, `Timeout`=0, `CycleCount`=20.
- Toggle `Req`/`ProgSel` during RUN, then keep `Req`=1 in DONE: no restart while `Req` stays 1. After `Req`=0 for 1 cycle, `Req`=1 with `ProgSel`=2 → `IF_Start_Addr`=128 and `CycleCount` restarts from 0.
- `Reset` during RUN at `CycleCount`=7: next cycle all outputs 0, state IDLE, and the IF PC is not advanced (`Run`=0).

Source files
------------

// File: rtl/program_sequencer.sv
// Run-control FSM for the fetch stage: loads a program's entry PC into IF,
// gates PC advance while the program runs, and reports halt/timeout completion.
module program_sequencer #(
  parameter int          NUM_PROGS  = 3,
  parameter logic [7:0]  PROG0_ADDR = 8'd0,
  parameter logic [7:0]  PROG1_ADDR = 8'd64,
  parameter logic [7:0]  PROG2_ADDR = 8'd128,
  parameter logic [7:0]  PROG3_ADDR = 8'd192,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic [1:0]  ProgSel,
  input  logic        Halt,
  output logic        IF_Start,
  output logic [7:0]  IF_Start_Addr,
  output logic        Run,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout,
  output logic        Err,
  output logic [15:0] CycleCount
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        sel_ok;

  function automatic logic [7:0] entry_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    entry_addr = PROG0_ADDR;
      2'd1:    entry_addr = PROG1_ADDR;
      2'd2:    entry_addr = PROG2_ADDR;
      default: entry_addr = PROG3_ADDR;
    endcase
  endfunction

  assign sel_ok = (int'(ProgSel) < NUM_PROGS);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          if (sel_ok) begin
            addr_d  = entry_addr(ProgSel);
            cnt_d   = 16'd0;
            tmo_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // The count includes the exiting cycle; halt takes priority over the watchdog.
        cnt_d = cnt_q + 16'd1;
        if (Halt) begin
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (!Req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= 8'd0;
      cnt_q   <= 16'd0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign IF_Start      = (state_q == S_LOAD);
  assign Run           = (state_q == S_RUN);
  assign Busy          = (state_q == S_LOAD) || (state_q == S_RUN);
  assign Done          = (state_q == S_DONE);
  assign Timeout       = tmo_q;
  assign Err           = err_q;
  assign CycleCount    = cnt_q;
  assign IF_Start_Addr = addr_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer (watchdog shortened to 20 cycles).
module tb_program_sequencer;

  localparam int LIMIT = 20;

  logic        CLK = 1'b0;
  logic        Reset, Req, Halt;
  logic [1:0]  ProgSel;
  logic        IF_Start, Run, Busy, Done, Timeout, Err;
  logic [7:0]  IF_Start_Addr;
  logic [15:0] CycleCount;

  int nchk = 0;
  int npass = 0;

  program_sequencer #(.NUM_PROGS(3), .TIMEOUT(16'(LIMIT))) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .ProgSel(ProgSel), .Halt(Halt),
    .IF_Start(IF_Start), .IF_Start_Addr(IF_Start_Addr), .Run(Run), .Busy(Busy),
    .Done(Done), .Timeout(Timeout), .Err(Err), .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Host-side stimulus: request a program and hold Halt high on RUN cycle halt_at
  // (0 = never). Returns what was observed; callers do the comparing.
  task automatic run_prog(input logic [1:0] sel, input int halt_at,
                          output int run_cyc, output int start_cyc,
                          output logic [7:0] start_addr, output logic [15:0] cnt_load);
    Req = 1'b1; ProgSel = sel;
    run_cyc = 0; start_cyc = 0; start_addr = 8'h00; cnt_load = 16'hFFFF;
    tick();
    while (IF_Start && start_cyc < 10) begin
      start_cyc++;
      start_addr = IF_Start_Addr;
      cnt_load = CycleCount;
      tick();
    end
    while (Run && run_cyc < 100) begin
      run_cyc++;
      Halt = (run_cyc == halt_at);
      tick();
    end
    Halt = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b1; ProgSel = 2'd1; Halt = 1'b1;
    tick(); tick();
    nchk++;
    if ({IF_Start, Run, Busy, Done, Timeout, Err, CycleCount, IF_Start_Addr} !== '0)
      $display("FAIL reset_outputs: got %b/%0d/%0d, want all zero",
               {IF_Start, Run, Busy, Done, Timeout, Err}, CycleCount, IF_Start_Addr);
    else npass++;
    Reset = 1'b0; Req = 1'b0; Halt = 1'b0;
    tick();
  endtask

  task automatic test_prog1_halt();
    Req = 1'b1; ProgSel = 2'd1;
    tick();
    nchk++;
    if ({IF_Start, Run, Busy, IF_Start_Addr} !== {1'b1, 1'b0, 1'b1, 8'd64})
      $display("FAIL load_cycle: start=%b run=%b busy=%b addr=%0d, want 1 0 1 64",
               IF_Start, Run, Busy, IF_Start_Addr);
    else npass++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      nchk++;
      if ({IF_Start, Run, Busy, CycleCount} !== {1'b0, 1'b1, 1'b1, 16'(i - 1)})
        $display("FAIL run_cycle_%0d: start=%b run=%b busy=%b cnt=%0d, want 0 1 1 %0d",
                 i, IF_Start, Run, Busy, CycleCount, i - 1);
      else npass++;
      Halt = (i == 5);
    end
    tick();
    Halt = 1'b0;
    nchk++;
    if ({Done, Run, Busy, Timeout, CycleCount} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd5})
      $display("FAIL halt_done: done=%b run=%b busy=%b tmo=%b cnt=%0d, want 1 0 0 0 5",
               Done, Run, Busy, Timeout, CycleCount);
    else npass++;
    Req = 1'b0;
    tick();
    nchk++;
    if ({Done, Busy, IF_Start} !== 3'b000)
      $display("FAIL back_to_idle: done=%b busy=%b start=%b, want 000", Done, Busy, IF_Start);
    else npass++;
  endtask

  task automatic test_bad_sel();
    Req = 1'b1; ProgSel = 2'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      nchk++;
      if ({Err, IF_Start, Busy, IF_Start_Addr} !== {1'b1, 1'b0, 1'b0, 8'd64})
        $display("FAIL bad_sel_%0d: err=%b start=%b busy=%b addr=%0d, want 1 0 0 64",
                 i, Err, IF_Start, Busy, IF_Start_Addr);
      else npass++;
    end
    Req = 1'b0;
    tick();
    nchk++;
    if (Err !== 1'b0) $display("FAIL err_clears: got %b want 0", Err);
    else npass++;
  endtask

  task automatic test_timeout();
    int rc, sc; logic [7:0] sa; logic [15:0] cl;
    run_prog(2'd0, 0, rc, sc, sa, cl);
    nchk++;
    if (rc !== LIMIT || {Done, Timeout, CycleCount} !== {1'b1, 1'b1, 16'(LIMIT)})
      $display("FAIL timeout: run_cycles=%0d done=%b tmo=%b cnt=%0d, want %0d 1 1 %0d",
               rc, Done, Timeout, CycleCount, LIMIT, LIMIT);
    else npass++;
    Req = 1'b0; tick();
  endtask

  task automatic test_halt_at_limit();
    int rc, sc; logic [7:0] sa; logic [15:0] cl;
    run_prog(2'd0, LIMIT, rc, sc, sa, cl);
    nchk++;
    if (rc !== LIMIT || {Done, Timeout, CycleCount} !== {1'b1, 1'b0, 16'(LIMIT)})
      $display("FAIL halt_at_limit: run_cycles=%0d done=%b tmo=%b cnt=%0d, want %0d 1 0 %0d",
               rc, Done, Timeout, CycleCount, LIMIT, LIMIT);
    else npass++;
    Req = 1'b0; tick();
  endtask

  task automatic test_no_restart();
    int rc, sc; logic [7:0] sa; logic [15:0] cl;
    Req = 1'b1; ProgSel = 2'd0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      Req = 1'($urandom); ProgSel = 2'($urandom);
      Halt = (i == 8);
    end
    Req = 1'b1;
    tick();
    Halt = 1'b0;
    nchk++;
    if ({Done, CycleCount, IF_Start_Addr} !== {1'b1, 16'd8, 8'd0})
      $display("FAIL run_ignores_req: done=%b cnt=%0d addr=%0d, want 1 8 0",
               Done, CycleCount, IF_Start_Addr);
    else npass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++;
      if ({Done, IF_Start, Busy} !== 3'b100)
        $display("FAIL done_hold_%0d: done=%b start=%b busy=%b, want 1 0 0", i, Done, IF_Start, Busy);
      else npass++;
    end
    Req = 1'b0; tick();
    run_prog(2'd2, 3, rc, sc, sa, cl);
    nchk++;
    if (sc !== 1 || sa !== 8'd128 || cl !== 16'd0 || CycleCount !== 16'd3 || Done !== 1'b1)
      $display("FAIL restart_prog2: starts=%0d addr=%0d cnt_load=%0d cnt=%0d done=%b, want 1 128 0 3 1",
               sc, sa, cl, CycleCount, Done);
    else npass++;
    Req = 1'b0; tick();
  endtask

  task automatic test_reset_mid_run();
    Req = 1'b1; ProgSel = 2'd1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    nchk++;
    if ({Run, CycleCount} !== {1'b1, 16'd7})
      $display("FAIL pre_reset_run: run=%b cnt=%0d, want 1 7", Run, CycleCount);
    else npass++;
    Reset = 1'b1;
    tick();
    nchk++;
    if ({IF_Start, Run, Busy, Done, Timeout, Err, CycleCount, IF_Start_Addr} !== '0)
      $display("FAIL reset_mid_run: got %b/%0d/%0d, want all zero",
               {IF_Start, Run, Busy, Done, Timeout, Err}, CycleCount, IF_Start_Addr);
    else npass++;
    Reset = 1'b0;
    tick();
    nchk++;
    if ({IF_Start, IF_Start_Addr} !== {1'b1, 8'd64})
      $display("FAIL accept_after_reset: start=%b addr=%0d, want 1 64", IF_Start, IF_Start_Addr);
    else npass++;
    Reset = 1'b1; Req = 1'b0; tick();
    Reset = 1'b0; tick();
  endtask

  task automatic test_random();
    logic [7:0] entry [4] = '{8'd0, 8'd64, 8'd128, 8'd192};
    int rc, sc, halt_at, exp_run;
    logic [7:0] sa; logic [15:0] cl; logic [1:0] sel; logic exp_tmo;
    logic [7:0] last_addr;
    last_addr = IF_Start_Addr;
    for (int n = 0; n < 12; n++) begin
      sel = 2'($urandom_range(0, 3));
      if (sel == 2'd3) begin
        Req = 1'b1; ProgSel = sel; tick();
        nchk++;
        if ({Err, Busy, IF_Start_Addr} !== {1'b1, 1'b0, last_addr})
          $display("FAIL rand_bad_%0d: err=%b busy=%b addr=%0d, want 1 0 %0d",
                   n, Err, Busy, IF_Start_Addr, last_addr);
        else npass++;
      end else begin
        halt_at = $urandom_range(0, LIMIT + 4);
        exp_tmo = !(halt_at >= 1 && halt_at <= LIMIT);
        exp_run = exp_tmo ? LIMIT : halt_at;
        run_prog(sel, halt_at, rc, sc, sa, cl);
        last_addr = entry[sel];
        nchk++;
        if (sc !== 1 || sa !== entry[sel] || rc !== exp_run || Done !== 1'b1 ||
            Timeout !== exp_tmo || CycleCount !== 16'(exp_run))
          $display("FAIL rand_run_%0d: sel=%0d halt_at=%0d starts=%0d addr=%0d runs=%0d done=%b tmo=%b cnt=%0d, want 1 %0d %0d 1 %b %0d",
                   n, sel, halt_at, sc, sa, rc, Done, Timeout, CycleCount,
                   entry[sel], exp_run, exp_tmo, exp_run);
        else npass++;
      end
      Req = 1'b0; Halt = 1'($urandom);
      tick();
      Halt = 1'b0;
      nchk++;
      if ({Done, Busy, IF_Start} !== 3'b000)
        $display("FAIL rand_idle_%0d: done=%b busy=%b start=%b, want 000", n, Done, Busy, IF_Start);
      else npass++;
    end
  endtask

  initial begin
    Reset = 1'b1; Req = 1'b0; ProgSel = 2'd0; Halt = 1'b0;
    test_reset();
    test_prog1_halt();
    test_bad_sel();
    test_timeout();
    test_halt_at_limit();
    test_no_restart();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
